// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between fetch (IF) and memory stage (DM).
// Optional round-robin grant selection when MEM_ARB_RR_EN is defined; fixed DM-over-IF otherwise.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_wr,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_done,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_stall,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err
);

    typedef enum logic {StIdle, StWait} state_e;

    localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

    state_e                state_q, state_d;
    logic                  owner_dm_q, owner_dm_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_done_q, if_done_d;
    logic                  dm_done_q, dm_done_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  err_q, err_d;

    logic                  if_elig, dm_elig, grant_dm;
    logic [DATA_WIDTH-1:0] ret_data;

    // A requester in its done cycle still holds req from the finished access.
    assign if_elig = if_req & ~if_done_q;
    assign dm_elig = dm_req & ~dm_done_q;

`ifdef MEM_ARB_RR_EN
    logic last_dm_q, last_dm_d;

    assign grant_dm = dm_elig & (~if_elig | ~last_dm_q);

    always_comb begin
        last_dm_d = last_dm_q;
        if (state_q == StIdle && (if_elig || dm_elig)) begin
            last_dm_d = grant_dm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`else
    assign grant_dm = dm_elig;
`endif

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        ret_data    = mem_wr_q ? '0 : mem_rdata;

        case (state_q)
            StIdle: begin
                if (if_elig || dm_elig) begin
                    state_d    = StWait;
                    owner_dm_d = grant_dm;
                    cnt_d      = 8'd0;
                    mem_req_d  = 1'b1;
                    if (grant_dm) begin
                        mem_addr_d  = dm_addr;
                        mem_wr_d    = dm_wr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_addr_d  = if_addr;
                        mem_wr_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_done) begin
                    state_d  = StIdle;
                    mem_wr_d = 1'b0;
                    if (owner_dm_q) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = ret_data;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = ret_data;
                    end
                end else if (cnt_q == TimeoutCnt) begin
                    // Abort: the requester is released with zero data and err latches.
                    state_d  = StIdle;
                    mem_wr_d = 1'b0;
                    err_d    = 1'b1;
                    if (owner_dm_q) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_dm_q  <= 1'b0;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters, a behavioural memory that predicts
// each grant and its completion, and a monitor that pops expectations on every done pulse.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 15;
`ifdef MEM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    typedef struct {
        logic [15:0] rdata;
        bit          timeout;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_done, if_stall;
    logic [15:0] if_addr, if_rdata;
    logic        dm_req, dm_wr, dm_done, dm_stall;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_wr, mem_done, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    exp_t        if_q[$];
    exp_t        dm_q[$];
    bit          if_pend = 1'b0, dm_pend = 1'b0, last_dm = 1'b0, err_model = 1'b0;
    bit          use_fix = 1'b0, hang_next = 1'b0, stray_req = 1'b0;
    int unsigned fix_lat = 0;
    logic [15:0] fix_rd = 16'h0;

    mem_port_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_wr    (dm_wr),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_done  (dm_done),
        .dm_rdata (dm_rdata),
        .dm_stall (dm_stall),
        .mem_req  (mem_req),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_done (mem_done),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requesters change inputs 2 time units after the rising edge.
    task automatic if_txn(input logic [15:0] a, input int unsigned gap);
        int unsigned n;
        if (gap > 0) begin
            @(posedge clk); #2;
            if_req = 1'b0;
            repeat (gap - 1) @(posedge clk);
        end
        @(posedge clk); #2;
        if_req = 1'b1; if_addr = a; if_pend = 1'b1;
        n = 0;
        while (!if_done && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (!if_done) begin
            chk("if_done_wait", 32'(if_done), 1);
            if_req = 1'b0;
        end
    endtask

    task automatic dm_txn(input logic [15:0] a, input logic w, input logic [15:0] d,
                          input int unsigned gap);
        int unsigned n;
        if (gap > 0) begin
            @(posedge clk); #2;
            dm_req = 1'b0;
            repeat (gap - 1) @(posedge clk);
        end
        @(posedge clk); #2;
        dm_req = 1'b1; dm_addr = a; dm_wr = w; dm_wdata = d; dm_pend = 1'b1;
        n = 0;
        while (!dm_done && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (!dm_done) begin
            chk("dm_done_wait", 32'(dm_done), 1);
            dm_req = 1'b0;
        end
    endtask

    task automatic if_drop();
        @(posedge clk); #2;
        if_req = 1'b0;
    endtask

    task automatic dm_drop();
        @(posedge clk); #2;
        dm_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_if_done"}, 32'(if_done), 0);
        chk({tag, "_dm_done"}, 32'(dm_done), 0);
        chk({tag, "_if_rdata"}, 32'(if_rdata), 0);
        chk({tag, "_dm_rdata"}, 32'(dm_rdata), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // Behavioural memory: predicts the winner of each grant and the completion it will produce.
    initial begin : mem_model
        bit          busy, cur_hang, w_dm;
        int unsigned left, lat;
        logic [15:0] cur_rd, cur_addr, cur_wdata;
        logic        cur_wr;
        exp_t        e;
        busy = 1'b0; cur_hang = 1'b0; left = 0;
        cur_rd = '0; cur_addr = '0; cur_wdata = '0; cur_wr = 1'b0;
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_done  = 1'b0;
            mem_rdata = 16'($urandom);
            if (rst) begin
                busy = 1'b0;
                continue;
            end
            if (mem_req) begin
                if (busy || (!if_pend && !dm_pend)) begin
                    chk("spurious_grant", 32'(mem_req), 0);
                end else begin
                    if (if_pend && dm_pend) w_dm = RrEn ? !last_dm : 1'b1;
                    else w_dm = dm_pend;
                    last_dm = w_dm;
                    if (w_dm) begin
                        cur_addr = dm_addr; cur_wr = dm_wr; cur_wdata = dm_wdata;
                        dm_pend = 1'b0;
                    end else begin
                        cur_addr = if_addr; cur_wr = 1'b0; cur_wdata = '0;
                        if_pend = 1'b0;
                    end
                    chk("grant_addr", 32'(mem_addr), 32'(cur_addr));
                    chk("grant_wr", 32'(mem_wr), 32'(cur_wr));
                    chk("grant_wdata", 32'(mem_wdata), 32'(cur_wdata));
                    lat       = use_fix ? fix_lat : $urandom_range(5, 0);
                    cur_rd    = use_fix ? fix_rd : 16'($urandom);
                    cur_hang  = hang_next;
                    hang_next = 1'b0;
                    e.rdata   = (cur_hang || cur_wr) ? 16'h0 : cur_rd;
                    e.timeout = cur_hang;
                    e.cyc     = cur_hang ? cyc + TO + 1 : cyc + lat + 1;
                    if (w_dm) dm_q.push_back(e);
                    else if_q.push_back(e);
                    busy = 1'b1;
                    left = cur_hang ? TO : lat;
                end
            end
            if (busy) begin
                chk("hold_addr", 32'(mem_addr), 32'(cur_addr));
                chk("hold_wr", 32'(mem_wr), 32'(cur_wr));
                chk("hold_wdata", 32'(mem_wdata), 32'(cur_wdata));
                if (left == 0) begin
                    busy = 1'b0;
                    if (!cur_hang) begin
                        mem_done  = 1'b1;
                        mem_rdata = cur_rd;
                    end
                end else begin
                    left--;
                end
            end else if (stray_req) begin
                mem_done  = 1'b1;
                stray_req = 1'b0;
            end
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation of its requester.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (if_done) begin
                if (if_q.size() == 0) begin
                    chk("if_spurious_done", 32'(if_done), 0);
                end else begin
                    e = if_q.pop_front();
                    if (e.timeout) err_model = 1'b1;
                    chk("if_rdata", 32'(if_rdata), 32'(e.rdata));
                    chk("if_done_cycle", cyc, e.cyc);
                    chk("err_flag", 32'(err), 32'(err_model));
                    chk("if_stall_on_done", 32'(if_stall), 0);
                    if (!e.timeout) chk("mem_wr_cleared", 32'(mem_wr), 0);
                end
            end else begin
                chk("if_stall", 32'(if_stall), 32'(if_req));
            end
            if (dm_done) begin
                if (dm_q.size() == 0) begin
                    chk("dm_spurious_done", 32'(dm_done), 0);
                end else begin
                    e = dm_q.pop_front();
                    if (e.timeout) err_model = 1'b1;
                    chk("dm_rdata", 32'(dm_rdata), 32'(e.rdata));
                    chk("dm_done_cycle", cyc, e.cyc);
                    chk("err_flag", 32'(err), 32'(err_model));
                    chk("dm_stall_on_done", 32'(dm_stall), 0);
                    if (!e.timeout) chk("mem_wr_cleared", 32'(mem_wr), 0);
                end
            end else begin
                chk("dm_stall", 32'(dm_stall), 32'(dm_req));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #3;
        rst = 1'b0;

        // Single fetch, latency 3.
        use_fix = 1'b1; fix_lat = 3; fix_rd = 16'hA5A5;
        if_txn(16'h0040, 1);
        if_drop();
        repeat (3) @(posedge clk);

        // Simultaneous requests, DM write against IF read.
        use_fix = 1'b0;
        fork
            begin dm_txn(16'h0100, 1'b1, 16'h1234, 1); dm_drop(); end
            begin if_txn(16'h0040, 1); if_drop(); end
        join
        repeat (3) @(posedge clk);

        // Three overlapping back-to-back request pairs.
        fork
            begin
                for (int i = 0; i < 3; i++) dm_txn(16'h0100 + 16'(i), 1'b1, 16'h1234, 0);
                dm_drop();
            end
            begin
                for (int i = 0; i < 3; i++) if_txn(16'h0040 + 16'(i), 0);
                if_drop();
            end
        join
        repeat (3) @(posedge clk);

        // Zero-latency DM read.
        use_fix = 1'b1; fix_lat = 0; fix_rd = 16'hBEEF;
        dm_txn(16'h8010, 1'b0, 16'h0, 1);
        dm_drop();
        use_fix = 1'b0;
        repeat (3) @(posedge clk);

        // Randomized traffic; IF addresses have bit 15 clear, DM addresses have it set.
        fork
            begin
                for (int i = 0; i < 60; i++)
                    dm_txn({1'b1, 15'($urandom)}, 1'($urandom), 16'($urandom),
                           $urandom_range(3, 0));
                dm_drop();
            end
            begin
                for (int i = 0; i < 60; i++)
                    if_txn({1'b0, 15'($urandom)}, $urandom_range(3, 0));
                if_drop();
            end
        join
        repeat (3) @(posedge clk);

        // Timeout, then err must stay set across normal transactions.
        hang_next = 1'b1;
        if_txn(16'h0200, 1);
        if_drop();
        @(negedge clk);
        chk("err_after_timeout", 32'(err), 1);
        dm_txn(16'h8200, 1'b0, 16'h0, 1);
        dm_drop();
        if_txn(16'h0210, 1);
        if_drop();
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of a WAIT, then a stray mem_done.
        hang_next = 1'b1;
        @(posedge clk); #2;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h8300; dm_wdata = 16'h5555; dm_pend = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        dm_req = 1'b0;
        if_q.delete(); dm_q.delete();
        if_pend = 1'b0; dm_pend = 1'b0; last_dm = 1'b0; err_model = 1'b0; hang_next = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #2;
        stray_req = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("err_after_stray", 32'(err), 0);
        chk("mem_req_after_stray", 32'(mem_req), 0);

        repeat (3) @(posedge clk);
        chk("if_queue_drained", if_q.size(), 0);
        chk("dm_queue_drained", dm_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the fetch stage (IF) and the memory stage (DM) of the 16-bit pipeline.
- Grants one requester at a time and holds the memory request stable until the memory reports completion.
- Returns read data and a one-cycle done pulse to the granted requester.
- Drives per-requester stall lines, which the pipeline ORs with the RAW-hazard stall.

Parameters:
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 16, data width.
- TIMEOUT, 15, maximum WAIT cycles without mem_done before the transaction is aborted (valid range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_done.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_done  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  DATA_WIDTH  fetch read data; valid when if_done=1.
- if_stall  out  1  fetch must hold.
- dm_req  in  1  data request; held until dm_done.
- dm_wr  in  1  1=write, 0=read.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  write data.
- dm_done  out  1  one-cycle completion pulse to the memory stage.
- dm_rdata  out  DATA_WIDTH  data read result; valid when dm_done=1 and the transaction was a read.
- dm_stall  out  1  memory stage must hold.
- mem_req  out  1  one-cycle issue pulse to memory.
- mem_wr  out  1  write enable; held through the transaction.
- mem_addr  out  ADDR_WIDTH  address; held through the transaction.
- mem_wdata  out  DATA_WIDTH  write data; held through the transaction.
- mem_done  in  1  memory completion; one-cycle pulse.
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_done.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, owner=none, timeout counter=0. All outputs 0: mem_req, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, err. Any in-flight transaction is dropped.
- Two states, IDLE and WAIT. The owner register records IF or DM.
- Eligibility in IDLE: a requester whose done output is 1 in the current cycle is not eligible that cycle. Its req is still high from the completed access; this rule prevents a duplicate grant.
- IDLE, on a clock edge with one or more eligible requests:
  - Default priority: DM wins over IF.
  - Latch the winner's address, write flag and write data onto mem_addr, mem_wr and mem_wdata. IF is always a read; for an IF grant, mem_wdata=0.
  - mem_req<=1, owner<=winner, counter<=0, state<=WAIT.
- WAIT:
  - mem_req<=0 after its single high cycle.
  - mem_addr, mem_wr and mem_wdata are held.
  - The counter increments each cycle.
- WAIT with mem_done=1:
  - Owner's done<=1 for exactly one cycle.
  - Owner's rdata<=mem_rdata for a read; rdata<=0 for a DM write.
  - mem_wr<=0, state<=IDLE.
  - mem_done is sampled from the first WAIT cycle, which is the same cycle mem_req is high, so zero-latency memory is supported.
- WAIT with counter==TIMEOUT and no mem_done:
  - err<=1 (sticky until rst).
  - Owner's done<=1 with rdata<=0, state<=IDLE.
  - A mem_done arriving later is ignored.
- mem_done while in IDLE is ignored and does not set err.
- Latency: req sampled at edge 0; mem_req high in cycle 1; with mem_done in cycle 1+N, x_done is high in cycle 2+N. The earliest next mem_req is cycle 3+N.
- Stall outputs (combinational):
  - if_stall = if_req & ~if_done.
  - dm_stall = dm_req & ~dm_done.
- rdata outputs keep their value between done pulses and are only meaningful while done=1.
- Requesters must hold req and payload stable until done. The arbiter does not re-sample them after the grant.
- Dropping req before done is illegal: the transaction still completes and the done pulse is still issued.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. A one-bit last-grant register (reset value = IF) is updated on every grant. When both requesters are eligible, the requester not granted last wins.
- Undefined: fixed DM-over-IF priority, and no last-grant register exists.

Test Plan:
- Single fetch, memory latency 3 (if_req=1, if_addr=16'h0040, mem_done 3 cycles after mem_req, mem_rdata=16'hA5A5) -> mem_req one cycle with mem_addr=16'h0040 and mem_wr=0; if_done=1 with if_rdata=16'hA5A5 exactly one cycle; if_stall=1 until that cycle; no second mem_req while if_req stays high in the done cycle.
- Simultaneous if_req and dm_req (dm_wr=1, dm_addr=16'h0100, dm_wdata=16'h1234), fixed priority -> DM issued first with mem_wr=1 and dm_done pulse with dm_rdata=0; IF issued next; if_stall=1 throughout.
- Same stimulus with MEM_ARB_RR_EN defined and 3 back-to-back overlapping request pairs -> grant order DM, IF, DM, IF, DM, IF.
- Memory never asserts mem_done, TIMEOUT=15 -> after 15 WAIT cycles the owner's done=1 with rdata=0 and err=1; err stays 1 through later normal transactions until rst.
- rst asserted asynchronously mid-WAIT, then a stray mem_done 2 cycles after release -> all outputs 0 immediately on rst; the stray mem_done produces no done pulse and err=0.
- Zero-latency memory (mem_done in the same cycle as mem_req) with dm_req read, mem_rdata=16'hBEEF -> dm_done with dm_rdata=16'hBEEF on the next cycle.
